// File: rtl/vga_timing_pkg.sv
// Shared constants, position type and helpers for the VGA raster timing generator.
// Default geometry is 640x480@60 with negative-polarity syncs.
package vga_timing_pkg;

    localparam int POS_W     = 10;
    localparam int MAX_TOTAL = 1 << POS_W;

    typedef logic [POS_W-1:0] pos_t;

    localparam int  H_ACTIVE_DFLT = 640;
    localparam int  H_FP_DFLT     = 16;
    localparam int  H_SYNC_DFLT   = 96;
    localparam int  H_BP_DFLT     = 48;
    localparam int  V_ACTIVE_DFLT = 480;
    localparam int  V_FP_DFLT     = 10;
    localparam int  V_SYNC_DFLT   = 2;
    localparam int  V_BP_DFLT     = 33;
    localparam bit  SYNC_ACT_DFLT = 1'b0;

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DFLT = axis_total(H_ACTIVE_DFLT, H_FP_DFLT, H_SYNC_DFLT, H_BP_DFLT);
    localparam int V_TOTAL_DFLT = axis_total(V_ACTIVE_DFLT, V_FP_DFLT, V_SYNC_DFLT, V_BP_DFLT);

    // Half-open interval test [lo, hi) on an unsigned position.
    function automatic logic in_range(pos_t p, int lo, int hi);
        return (int'(p) >= lo) && (int'(p) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the pixel stage (slave).
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if;

    logic                  ena;
    vga_timing_pkg::pos_t  hpos;
    vga_timing_pkg::pos_t  vpos;
    logic                  hsync;
    logic                  vsync;
    logic                  display_on;
    logic                  line_req;
    vga_timing_pkg::pos_t  next_row;
    logic                  frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]            frame_cnt;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        input  ena,
        output hpos, vpos, hsync, vsync, display_on, line_req, next_row, frame_start
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        output ena,
        input  hpos, vpos, hsync, vsync, display_on, line_req, next_row, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active/sync decodes
// taken from the next-state position so they stay aligned with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic wrap,
    output pos_t pos,
    output logic active,
    output logic sync_on
);

    localparam pos_t LAST = pos_t'(TOTAL - 1);

    pos_t pos_reg, pos_next;
    logic active_reg, sync_on_reg;

    assign wrap = inc && (pos_reg == LAST);

    always_comb begin
        pos_next = pos_reg;
        if (inc) begin
            pos_next = wrap ? '0 : pos_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg     <= LAST;
            active_reg  <= 1'b0;
            sync_on_reg <= 1'b0;
        end else begin
            pos_reg     <= pos_next;
            active_reg  <= in_range(pos_next, 0, ACTIVE);
            sync_on_reg <= in_range(pos_next, SYNC_START, SYNC_END);
        end
    end

    assign pos     = pos_reg;
    assign active  = active_reg;
    assign sync_on = sync_on_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, syncs, display enable, next-row request pulse.
// Optional 8-bit frame counter on the bundle when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int H_FP     = H_FP_DFLT,
    parameter int H_SYNC   = H_SYNC_DFLT,
    parameter int H_BP     = H_BP_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT,
    parameter int V_FP     = V_FP_DFLT,
    parameter int V_SYNC   = V_SYNC_DFLT,
    parameter int V_BP     = V_BP_DFLT,
    parameter bit SYNC_ACT = SYNC_ACT_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_timing_gen: raster totals must not exceed %0d", MAX_TOTAL);
        end
    endgenerate

    logic h_wrap, v_wrap;
    pos_t h_pos, v_pos;
    logic h_active, v_active, h_sync_on, v_sync_on;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (vga.ena),
        .wrap    (h_wrap),
        .pos     (h_pos),
        .active  (h_active),
        .sync_on (h_sync_on)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (h_wrap),
        .wrap    (v_wrap),
        .pos     (v_pos),
        .active  (v_active),
        .sync_on (v_sync_on)
    );

    pos_t v_following;
    logic line_req_reg, line_req_next;
    pos_t next_row_reg, next_row_next;
    logic frame_start_reg, frame_start_next;

    // The request fires on the edge into hpos==H_ACTIVE; vpos cannot change on that edge.
    always_comb begin
        v_following      = (v_pos == pos_t'(V_TOTAL - 1)) ? '0 : v_pos + 1'b1;
        line_req_next    = vga.ena && (h_pos == pos_t'(H_ACTIVE - 1))
                           && in_range(v_following, 0, V_ACTIVE);
        next_row_next    = line_req_next ? v_following : next_row_reg;
        frame_start_next = v_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_req_reg    <= 1'b0;
            next_row_reg    <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            line_req_reg    <= line_req_next;
            next_row_reg    <= next_row_next;
            frame_start_reg <= frame_start_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (frame_start_next) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_reg;
`endif

    assign vga.hpos        = h_pos;
    assign vga.vpos        = v_pos;
    assign vga.hsync       = h_sync_on ? SYNC_ACT : ~SYNC_ACT;
    assign vga.vsync       = v_sync_on ? SYNC_ACT : ~SYNC_ACT;
    assign vga.display_on  = h_active & v_active;
    assign vga.line_req    = line_req_reg;
    assign vga.next_row    = next_row_reg;
    assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen against a linear-pixel-index reference model.
// A reduced raster geometry keeps multi-frame runs short.
module tb_vga_timing_gen;

    localparam int HA = 8, HFP = 2, HS = 4, HBP = 6;
    localparam int VA = 5, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam bit SACT = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if vif ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_ACT (SACT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raster position as a single pixel index within the frame.
    int pix, exp_req, exp_row, exp_fs, exp_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pix = FRAME - 1; exp_req = 0; exp_row = 0; exp_fs = 0; exp_fcnt = 0;
    endtask

    task automatic model_step(input bit e);
        int h, v;
        exp_req = 0;
        exp_fs  = 0;
        if (e) begin
            pix = (pix + 1) % FRAME;
            h = pix % HT;
            v = pix / HT;
            if (h == HA && ((v + 1) % VT) < VA) begin
                exp_req = 1;
                exp_row = (v + 1) % VT;
            end
            if (pix == 0) begin
                exp_fs   = 1;
                exp_fcnt = (exp_fcnt + 1) % 256;
            end
        end
    endtask

    task automatic check_all(input string phase);
        int h, v;
        h = pix % HT;
        v = pix / HT;
        check({phase, ".hpos"}, 32'(vif.hpos), h);
        check({phase, ".vpos"}, 32'(vif.vpos), v);
        check({phase, ".hsync"}, 32'(vif.hsync),
              (h >= HA + HFP && h < HA + HFP + HS) ? 32'(SACT) : 32'(!SACT));
        check({phase, ".vsync"}, 32'(vif.vsync),
              (v >= VA + VFP && v < VA + VFP + VS) ? 32'(SACT) : 32'(!SACT));
        check({phase, ".display_on"}, 32'(vif.display_on), (h < HA && v < VA) ? 1 : 0);
        check({phase, ".line_req"}, 32'(vif.line_req), exp_req);
        check({phase, ".next_row"}, 32'(vif.next_row), exp_row);
        check({phase, ".frame_start"}, 32'(vif.frame_start), exp_fs);
`ifdef VGA_FRAME_CNT_EN
        check({phase, ".frame_cnt"}, 32'(vif.frame_cnt), exp_fcnt);
`endif
    endtask

    task automatic tick(input bit e, input string phase);
        vif.ena = e;
        @(posedge clk);
        model_step(e);
        @(negedge clk);
        check_all(phase);
    endtask

    initial begin
        int hs_low, vs_low, req_cnt, fs_cnt, req_wrap, gap, pulses;
        vif.ena = 1'b1;
        model_reset();

        // Reset held with ena high: raster parked at the last pixel.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all("reset");
        end
        check("reset.hsync_high", 32'(vif.hsync), 1);
        rst = 1'b0;

        tick(1'b1, "first");
        check("first.origin", {vif.vpos, vif.hpos}, 0);
        check("first.frame_start", 32'(vif.frame_start), 1);
        check("first.display_on", 32'(vif.display_on), 1);

        // One full frame with ena high.
        hs_low = 0; vs_low = 0; req_cnt = 0; fs_cnt = 0; req_wrap = 0;
        for (int i = 1; i <= FRAME; i++) begin
            tick(1'b1, "frame");
            if (vif.vpos == 0 && vif.hsync == SACT) hs_low++;
            if (vif.vsync == SACT) vs_low++;
            if (vif.line_req) req_cnt++;
            if (vif.line_req && vif.vpos == VT - 1 && vif.next_row == 0) req_wrap++;
            if (vif.frame_start) fs_cnt++;
        end
        check("sweep.hsync_width", hs_low, HS);
        check("sweep.vsync_cycles", vs_low, VS * HT);
        check("row.req_per_frame", req_cnt, VA);
        check("row.req_on_last_line", req_wrap, 1);
        check("frame.single_start", fs_cnt, 1);
        check("frame.back_at_origin", {vif.vpos, vif.hpos}, 0);

        // Random enable pattern; measure frame period in enabled cycles.
        gap = 0; pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            bit e;
            e = ($urandom_range(0, 3) != 0);
            tick(e, "rand");
            if (e) gap++;
            if (vif.frame_start) begin
                if (pulses > 0) check("rand.frame_period", gap, FRAME);
                pulses++;
                gap = 0;
            end
        end

        // Freeze at (3,2) for 37 cycles.
        while (pix != 2 * HT + 3) tick(1'b1, "seek");
        pulses = 0;
        for (int i = 0; i < 37; i++) begin
            tick(1'b0, "freeze");
            pulses += int'(vif.line_req) + int'(vif.frame_start);
        end
        check("freeze.pos", {vif.vpos, vif.hpos}, {10'd2, 10'd3});
        check("freeze.no_pulses", pulses, 0);
        tick(1'b1, "resume");
        check("resume.hpos", 32'(vif.hpos), 4);

        // Asynchronous reset mid-line, between clock edges.
        while (pix != 3 * HT + 12) tick(1'b1, "seek");
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all("async_rst_hold");
        rst = 1'b0;

`ifdef VGA_FRAME_CNT_EN
        for (int i = 0; i < 2 * FRAME + 1; i++) tick(1'b1, "fcnt");
        check("fcnt.three", 32'(vif.frame_cnt), 3);
        for (int i = 0; i < 252 * FRAME; i++) tick(1'b1, "fcnt");
        check("fcnt.max", 32'(vif.frame_cnt), 255);
        for (int i = 0; i < FRAME; i++) tick(1'b1, "fcnt");
        check("fcnt.wrap", 32'(vif.frame_cnt), 0);
`else
        for (int i = 0; i < FRAME + 1; i++) tick(1'b1, "post_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the TinyTapeout VGA designs. It produces horizontal and vertical pixel counters, sync pulses and a display-enable signal. It sits directly upstream of the row-by-row pixel generator inside `tt_um_Arya_vga_rowByrow`. It also issues a per-row request pulse one blanking interval ahead, so the downstream stage can prepare the next row's data before that row becomes visible.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `SYNC_ACT`, 0: active level of hsync/vsync (0 = negative polarity)

Ports:
- `clk`  in  1  pixel clock (25 MHz nominal)
- `rst`  in  1  asynchronous, active-high reset
- `ena`  in  1  advance enable; low freezes the raster
- `hpos`  out  10  current column
- `vpos`  out  10  current line
- `hsync`  out  1  horizontal sync, level `SYNC_ACT` when asserted
- `vsync`  out  1  vertical sync, level `SYNC_ACT` when asserted
- `display_on`  out  1  high when `hpos < H_ACTIVE` and `vpos < V_ACTIVE`
- `line_req`  out  1  one-cycle pulse requesting the next visible row
- `next_row`  out  10  row number accompanying `line_req`
- `frame_start`  out  1  one-cycle pulse on entering (0,0)
- `frame_cnt`  out  8  frame counter (present only with `VGA_FRAME_CNT_EN`)

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800) and `V_TOTAL` (525). Both must be ≤ 1024; elaboration fails otherwise.
- **Horizontal counter:**
  - Counts 0..`H_TOTAL-1` on each cycle with `ena=1`.
  - At `H_TOTAL-1` it wraps to 0 and the vertical counter advances.
  - The vertical counter wraps from `V_TOTAL-1` to 0.
- **Sync decode:**
  - hsync is asserted for `H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC` (656..751).
  - vsync is asserted for `V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC` (490..491).
- **Reset state:**
  - `hpos=H_TOTAL-1`, `vpos=V_TOTAL-1`.
  - hsync and vsync at `!SYNC_ACT`; `display_on=0`; `line_req=0`, `next_row=0`, `frame_start=0`, `frame_cnt=0`.
  - The first enabled edge after reset release lands on (0,0) with `frame_start=1`.
- **Row request:**
  - `line_req` pulses in the cycle where `hpos==H_ACTIVE`, provided the line after the current one (wrapping at `V_TOTAL`) is `< V_ACTIVE`.
  - `next_row` equals that line number and holds its value until the next pulse.
  - Example: on line 524 the pulse is issued with `next_row=0`. Lines 479..523 issue no pulse.
- **`ena=0`:** all counters and level outputs hold their values; `line_req` and `frame_start` are forced to 0.
- **Reset mid-frame:** counters return to the reset state immediately, with no completion of the current line.

## Timing
- All outputs are registered. Each is decoded from the next-state counter values, so every output is coherent with `hpos`/`vpos` in the same cycle; there is zero relative skew.
- Latency from a counter value to its decode is 0 cycles, as seen at the outputs.
- A pulse lasts exactly one enabled cycle.
- `line_req` leads the first pixel of `next_row` by `H_TOTAL-H_ACTIVE` = 160 cycles.
- When horizontal and vertical wrap occur together at (799,524), both counters go to (0,0) on the same edge.

## Configuration
- **`VGA_FRAME_CNT_EN` defined:**
  - The `frame_cnt` port and an 8-bit counter are present.
  - The counter increments in the same cycle that `frame_start` is asserted and wraps from 255 to 0.
  - The downstream generator uses it for animation.
- **Not defined:** the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480@60 constants;
  - the derived `H_TOTAL`/`V_TOTAL` expressions;
  - the `pos_t` typedef (10-bit position).
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical):
  - parameters `TOTAL`, `ACTIVE`, `SYNC_START`, `SYNC_END`;
  - ports: an increment enable, a wrap output, and registered `pos`, `active` and `sync_on` outputs.
- The top level chains the horizontal wrap into the vertical increment. It also holds the row-request and frame-counter logic.

## Test plan
- **Reset check:** hold `rst` high, then release with `ena=1`.
  - During reset: (799,524), `display_on=0`, hsync=vsync=1.
  - First edge: (0,0), `frame_start=1`, `display_on=1`.
- **Horizontal sweep:** on line 0, hsync=0 exactly for `hpos` 656..751; `display_on` falls at `hpos=640`; `hpos` wraps 799→0 and `vpos` goes 0→1.
- **Row request:**
  - Line 5: `line_req` pulses once at `hpos=640` with `next_row=6`.
  - Line 479: no pulse.
  - Line 524: pulse with `next_row=0`.
- **Vertical sync and frame period:** vsync=0 on exactly lines 490 and 491. `frame_start` pulses every 420000 enabled cycles.
- **Freeze:** drop `ena` for 37 cycles at (100,200). Outputs hold and no pulses occur; on resume the raster continues at (101,200).
- **Mid-frame reset and frame counter:**
  - Assert `rst` at (300,250): outputs return to the reset state within the same cycle.
  - With `VGA_FRAME_CNT_EN`, `frame_cnt` reads 3 after three frame starts and wraps 255→0.
